// File: rtl/cal_btn_pulse.sv
// cal_btn_pulse: input conditioning for the calculator FSM.
// Synchronizes, debounces and edge-converts the raw "+" and "-" buttons into
// single-clock pulses on in1 / in2. "+" wins when both fire on the same cycle.
// Optional auto-repeat while a button is held: define CAL_BTN_REPEAT_EN.
module cal_btn_pulse #(
    parameter int SAMPLE_DIV = 100000,
    parameter int DB_DEPTH   = 4,
    parameter int CNT_W      = 17
`ifdef CAL_BTN_REPEAT_EN
    ,
    parameter int REPEAT_DLY = 500,
    parameter int REPEAT_PER = 200
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_add_raw,
    input  logic btn_sub_raw,
    output logic in1,
    output logic in2,
    output logic add_level,
    output logic sub_level,
    output logic tick
);

    typedef enum logic [1:0] {IDLE, FIRE, HELD} state_t;

    // Channel index: 0 is "+", 1 is "-". Channel 0 has priority.
    localparam int ADD = 0;
    localparam int SUB = 1;

    logic [1:0]                sync1;
    logic [1:0]                sync2;
    logic [CNT_W-1:0]          cnt;
    logic                      tick_q;
    logic [1:0][DB_DEPTH-1:0]  sr;
    logic [1:0][DB_DEPTH-1:0]  sr_next;
    logic [1:0]                level;
    logic [1:0]                level_next;
    logic [1:0]                pulse;
    logic [1:0]                fire_req;
    logic [1:0]                fire_ok;
    state_t                    state [2];

`ifdef CAL_BTN_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt [2];
    logic [1:0]       rep_first;
    logic [1:0]       rep_due;

    // A held channel is due to re-fire once it has seen the initial delay,
    // and afterwards every repeat period.
    always_comb begin
        rep_due = '0;
        for (int i = 0; i < 2; i++) begin
            rep_due[i] = (rep_cnt[i] == (rep_first[i] ? REP_W'(REPEAT_DLY)
                                                      : REP_W'(REPEAT_PER)));
        end
    end
`endif

    // Two-flop synchronizer per button; only the second stage is used.
    // NOTE: asynchronous reset belongs in the sensitivity list, and sequential
    // state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {btn_sub_raw, btn_add_raw};
            sync2 <= sync1;
        end
    end

    // Sample-tick divider; tick is registered so it is high while cnt == SAMPLE_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt    <= (cnt == CNT_W'(SAMPLE_DIV - 1)) ? '0 : cnt + 1'b1;
            tick_q <= (cnt == CNT_W'(SAMPLE_DIV - 2));
        end
    end

    // Next shift-register contents, next debounced level and pulse arbitration.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        sr_next    = sr;
        level_next = level;
        fire_req   = '0;
        for (int i = 0; i < 2; i++) begin
            if (tick_q) begin
                sr_next[i] = {sr[i][DB_DEPTH-2:0], sync2[i]};
            end
            if (&sr_next[i]) begin
                level_next[i] = 1'b1;
            end else if (~|sr_next[i]) begin
                level_next[i] = 1'b0;
            end
            case (state[i])
                IDLE:    fire_req[i] = level[i];
`ifdef CAL_BTN_REPEAT_EN
                HELD:    fire_req[i] = level[i] && rep_due[i];
`endif
                default: fire_req[i] = 1'b0;
            endcase
        end
        // "-" may only fire on a cycle where "+" does not.
        fire_ok[ADD] = fire_req[ADD];
        fire_ok[SUB] = fire_req[SUB] && !fire_req[ADD];
    end

    // Debounce shift registers and the debounced levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr    <= '0;
            level <= '0;
        end else begin
            sr    <= sr_next;
            level <= level_next;
        end
    end

    // Per-channel IDLE/FIRE/HELD FSM with the pulse registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state[ADD] <= IDLE;
            state[SUB] <= IDLE;
            pulse      <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                pulse[i] <= 1'b0;
                case (state[i])
                    IDLE: begin
                        if (level[i]) begin
                            // A losing channel skips FIRE so that press never pulses.
                            if (fire_ok[i]) begin
                                state[i] <= FIRE;
                                pulse[i] <= 1'b1;
                            end else begin
                                state[i] <= HELD;
                            end
                        end
                    end
                    FIRE: state[i] <= HELD;
                    HELD: begin
                        if (!level[i]) begin
                            state[i] <= IDLE;
                        end else if (fire_ok[i]) begin
                            state[i] <= FIRE;
                            pulse[i] <= 1'b1;
                        end
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

`ifdef CAL_BTN_REPEAT_EN
    // Repeat tick counters: run only in HELD, restart on every (granted or dropped) repeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt[ADD] <= '0;
            rep_cnt[SUB] <= '0;
            rep_first    <= '1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (state[i])
                    IDLE: begin
                        rep_cnt[i]   <= '0;
                        rep_first[i] <= 1'b1;
                    end
                    HELD: begin
                        if (fire_req[i]) begin
                            rep_cnt[i]   <= '0;
                            rep_first[i] <= 1'b0;
                        end else if (tick_q) begin
                            rep_cnt[i] <= rep_cnt[i] + 1'b1;
                        end
                    end
                    default: rep_cnt[i] <= '0;
                endcase
            end
        end
    end
`endif

    assign in1       = pulse[ADD];
    assign in2       = pulse[SUB];
    assign add_level = level[ADD];
    assign sub_level = level[SUB];
    assign tick      = tick_q;

endmodule

// File: tb/tb_cal_btn_pulse.sv
// Directed bench for cal_btn_pulse with SAMPLE_DIV=4, DB_DEPTH=3.
// Stimulus pushes expected pulses (channel, cycle since reset release) into a
// queue; an independent monitor pops one entry for every pulse the DUT emits.
module tb_cal_btn_pulse;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_add_raw = 1'b0;
    logic btn_sub_raw = 1'b0;
    logic in1, in2, add_level, sub_level, tick;

    typedef struct {
        logic ch;   // 0 = in1, 1 = in2
        int   cyc;  // cycle count at which the pulse must be high
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc;

    cal_btn_pulse #(
        .SAMPLE_DIV(4),
        .DB_DEPTH  (3),
        .CNT_W     (2)
`ifdef CAL_BTN_REPEAT_EN
        ,
        .REPEAT_DLY(5),
        .REPEAT_PER(2)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_add_raw(btn_add_raw),
        .btn_sub_raw(btn_sub_raw),
        .in1        (in1),
        .in2        (in2),
        .add_level  (add_level),
        .sub_level  (sub_level),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    // Cycles elapsed since the last reset release; ticks land on cyc % 4 == 3.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, expv, cyc);
        end
    endtask

    task automatic wait_to(input int n);
        int guard = 0;
        while (cyc < n) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                $display("FAIL wait_to: stuck at cyc %0d waiting for %0d", cyc, n);
                $fatal(1, "bench timeout");
            end
        end
    endtask

    task automatic expect_pulse(input logic ch, input int c);
        exp_t x;
        x.ch  = ch;
        x.cyc = c;
        exp_q.push_back(x);
    endtask

    // Monitor: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n && (in1 || in2)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, in2, in1}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_ch", {30'd0, in2, in1}, e.ch ? 32'd2 : 32'd1);
                check("pulse_cyc", cyc, e.cyc);
            end
        end
    end

    initial begin
        bit bounce [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // 1. Reset then idle.
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_outputs", {27'd0, in1, in2, add_level, sub_level, tick}, 32'd0);
        for (int n = 1; n <= 12; n++) begin
            wait_to(n);
            check("idle_tick", tick, ((n % 4) == 3) ? 32'd1 : 32'd0);
            check("idle_outputs", {28'd0, in1, in2, add_level, sub_level}, 32'd0);
        end

        // 2. Clean "+" press at cyc 13: ticks 15,19,23 -> level at 24, in1 at 25.
        wait_to(13);
        btn_add_raw = 1'b1;
        expect_pulse(1'b0, 25);
`ifdef CAL_BTN_REPEAT_EN
        expect_pulse(1'b0, 45);
        expect_pulse(1'b0, 53);
        expect_pulse(1'b0, 61);
`endif
        wait_to(23); check("add_level_pre", add_level, 32'd0);
        wait_to(24); check("add_level_rise", add_level, 32'd1);
        wait_to(53); btn_add_raw = 1'b0;
        wait_to(63); check("add_level_hold", add_level, 32'd1);
        wait_to(64); check("add_level_fall", add_level, 32'd0);

        // 3. Bounce on "-": samples 1,1,0,1,0,1 on ticks 71..91, then 0.
        for (int j = 0; j < 10; j++) begin
            wait_to(68 + 4 * j);
            check("bounce_sub_level", sub_level, 32'd0);
            btn_sub_raw = (j < 6) ? bounce[j] : 1'b0;
        end

        // 4. Simultaneous press at 105: both levels at 116, only in1 at 117.
        wait_to(105);
        btn_add_raw = 1'b1;
        btn_sub_raw = 1'b1;
        expect_pulse(1'b0, 117);
`ifdef CAL_BTN_REPEAT_EN
        expect_pulse(1'b0, 137);
        expect_pulse(1'b0, 145);
        expect_pulse(1'b0, 153);
`endif
        wait_to(115); check("both_levels_pre", {30'd0, add_level, sub_level}, 32'd0);
        wait_to(116); check("both_levels_rise", {30'd0, add_level, sub_level}, 32'd3);
        wait_to(145);
        btn_add_raw = 1'b0;
        btn_sub_raw = 1'b0;
        wait_to(156); check("both_levels_fall", {30'd0, add_level, sub_level}, 32'd0);
        // "-" alone at 160: ticks 163,167,171 -> level 172, in2 at 173.
        wait_to(160);
        btn_sub_raw = 1'b1;
        expect_pulse(1'b1, 173);
        wait_to(172); check("sub_level_rise", sub_level, 32'd1);
        wait_to(180); btn_sub_raw = 1'b0;
        wait_to(192); check("sub_level_fall", sub_level, 32'd0);

        // 5. Reset two cycles after an in1 pulse, button still held.
        wait_to(200);
        btn_add_raw = 1'b1;
        expect_pulse(1'b0, 213);
        wait_to(212); check("pre_reset_level", add_level, 32'd1);
        wait_to(215);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", {27'd0, in1, in2, add_level, sub_level, tick}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // Counting restarts: ticks 3,7,11 -> level 12, in1 at 13.
        expect_pulse(1'b0, 13);
`ifdef CAL_BTN_REPEAT_EN
        expect_pulse(1'b0, 33);
        expect_pulse(1'b0, 41);
`endif
        wait_to(11); check("requal_level_pre", add_level, 32'd0);
        wait_to(12); check("requal_level_rise", add_level, 32'd1);
        wait_to(30); btn_add_raw = 1'b0;
        wait_to(44); check("requal_level_fall", add_level, 32'd0);

`ifdef CAL_BTN_REPEAT_EN
        // 6. Hold "-" 60 cycles: in2 at 73, +20, then every 8 while level is 1.
        wait_to(60);
        btn_sub_raw = 1'b1;
        expect_pulse(1'b1, 73);
        expect_pulse(1'b1, 93);
        expect_pulse(1'b1, 101);
        expect_pulse(1'b1, 109);
        expect_pulse(1'b1, 117);
        expect_pulse(1'b1, 125);
        wait_to(120); btn_sub_raw = 1'b0;
        wait_to(131); check("rep_sub_level_hold", sub_level, 32'd1);
        wait_to(132); check("rep_sub_level_fall", sub_level, 32'd0);
`endif

        wait_to(140);
        check("expected_pulses_left", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
